bsg_fifo_rolly_pkt_writer: RTL

// - Upstream stage of bsg_fifo_1r1w_rolly*: turns a packetized valid/ready word stream into

---
 rtl/bsg_fifo_rolly_pkt_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bsg_fifo_rolly_pkt_writer.sv
// Packet writer for bsg_fifo_1r1w_rolly*: streams words into the FIFO and commits or drops each packet.
// Optional BSG_FIFO_ROLLY_PKT_WRITER_DROP_ON_FULL_EN: never backpressure; a word arriving while the FIFO is full drops its packet.
module bsg_fifo_rolly_pkt_writer #(
  parameter int width_p       = 8,
  parameter int max_words_p   = 4,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     last_i,
  input  logic                     err_i,
  output logic                     ready_o,

  output logic                     fifo_v_o,
  output logic [width_p-1:0]       fifo_data_o,
  input  logic                     fifo_ready_i,
  output logic                     fifo_commit_not_drop_v_o,
  output logic                     fifo_commit_not_drop_o,

  output logic [count_width_p-1:0] commit_cnt_o,
  output logic [count_width_p-1:0] drop_cnt_o
);

  localparam int words_width_lp = $clog2(max_words_p + 1);

  typedef enum logic {
    eRecv,
    eDiscard
  } state_e;

  state_e                    state_q,      state_d;
  logic [words_width_lp-1:0] cnt_q,        cnt_d;
  logic [count_width_p-1:0]  commit_cnt_q, commit_cnt_d;
  logic [count_width_p-1:0]  drop_cnt_q,   drop_cnt_d;

  logic recv_ready;
  logic full_drop;
  logic accept;
  logic drop_c;
  logic at_max;

`ifdef BSG_FIFO_ROLLY_PKT_WRITER_DROP_ON_FULL_EN
  assign recv_ready = 1'b1;
  assign full_drop  = ~fifo_ready_i;
`else
  assign recv_ready = fifo_ready_i;
  assign full_drop  = 1'b0;
`endif

  assign at_max = (cnt_q == words_width_lp'(max_words_p));
  assign drop_c = err_i | at_max | full_drop;

  // Gating with reset_i keeps every handshake quiet while the FIFO is also being reset.
  assign ready_o = ~reset_i & ((state_q == eDiscard) ? 1'b1 : recv_ready);
  assign accept  = v_i & ready_o;

  assign fifo_data_o = data_i;

  // NOTE: always_comb assigns every output a default first so no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d                  = state_q;
    cnt_d                    = cnt_q;
    commit_cnt_d             = commit_cnt_q;
    drop_cnt_d               = drop_cnt_q;
    fifo_v_o                 = 1'b0;
    fifo_commit_not_drop_v_o = 1'b0;
    fifo_commit_not_drop_o   = 1'b0;

    unique case (state_q)
      eRecv: begin
        if (accept) begin
          if (drop_c) begin
            fifo_commit_not_drop_v_o = 1'b1;
            fifo_commit_not_drop_o   = 1'b0;
            drop_cnt_d               = drop_cnt_q + count_width_p'(1);
            cnt_d                    = '0;
            state_d                  = last_i ? eRecv : eDiscard;
          end else begin
            fifo_v_o = 1'b1;
            if (last_i) begin
              fifo_commit_not_drop_v_o = 1'b1;
              fifo_commit_not_drop_o   = 1'b1;
              commit_cnt_d             = commit_cnt_q + count_width_p'(1);
              cnt_d                    = '0;
            end else begin
              cnt_d = cnt_q + words_width_lp'(1);
            end
          end
        end
      end

      eDiscard: begin
        // The drop was already signalled on entry; just swallow words up to last_i.
        if (accept && last_i) begin
          state_d = eRecv;
        end
      end

      default: state_d = eRecv;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= eRecv;
      cnt_q        <= '0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign commit_cnt_o = commit_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
